ternary_neuron: RTL and testbench

Parametrised single-neuron engine for the ternary network. It streams `N_INPUTS` signed activations against ternary weights through a valid/ready handshake and accumulates them with saturation. It then adds a signed bias and applies a selectable activation (none, sign, ReLU). Every hidden and output layer instantiates it in place of the fixed-width per-layer neuron blocks, and the layer sequencer drives it.

---
 rtl/tnn_pkg.sv | 20 ++
 rtl/ternary_term.sv | 27 ++
 rtl/ternary_neuron.sv | 138 +++++++++++++
 tb/tb_ternary_neuron.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared constants for the ternary network: weight codes, activation modes, neuron FSM encoding.
package tnn_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_RSVD = 2'b10;
  localparam logic [1:0] W_NEG  = 2'b11;

  localparam int ACT_NONE = 0;
  localparam int ACT_SIGN = 1;
  localparam int ACT_RELU = 2;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCUM  = 2'd1;
  localparam state_t S_FINISH = 2'd2;
  localparam state_t S_OUT    = 2'd3;

endpackage

// File: rtl/ternary_term.sv
// Signed activation times ternary weight, one bit wider than the input so negating the minimum is exact.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ternary_term
  import tnn_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic signed [IN_W-1:0] data,
  input  logic        [1:0]      weight,
  output logic signed [IN_W:0]   prod
);

  logic signed [IN_W:0] data_ext;

  assign data_ext = {data[IN_W-1], data};

  always_comb begin
    prod = '0;
    case (weight)
      W_POS:   prod = data_ext;
      W_NEG:   prod = -data_ext;
      default: prod = '0;  // zero and the reserved code both contribute nothing
    endcase
  end

endmodule

// File: rtl/ternary_neuron.sv
// Streams N_INPUTS ternary products into a saturating accumulator, adds bias, clamps and activates.
// Latency: N_INPUTS+2 cycles from start with a gap-free term stream.
// Backpressure: in_ready only in ACCUM (state-derived); the result is held in OUT until out_ready.
module ternary_neuron
  import tnn_pkg::*;
#(
  parameter int N_INPUTS = 64,
  parameter int IN_W     = 2,
  parameter int ACC_W    = 8,
  parameter int BIAS_W   = 4,
  parameter int OUT_W    = 7,
  parameter int ACT      = 0,
  localparam int IDX_W   = $clog2(N_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in_data,
  input  logic        [1:0]        in_weight,
  output logic        [IDX_W-1:0]  in_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  result,
  output logic                     sat,
  output logic                     busy
);

  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [IDX_W-1:0]   idx;
  logic signed [BIAS_W-1:0]  bias_q;
  logic                      sat_acc;

  logic signed [IN_W:0]      prod;
  logic signed [ACC_W:0]     acc_sum;
  logic                      acc_ovf;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W:0]     fin_sum;
  logic                      fin_clamp;
  logic signed [OUT_W-1:0]   fin_clamped;
  logic signed [OUT_W-1:0]   act_val;

  ternary_term #(.IN_W(IN_W)) u_term (
    .data   (in_data),
    .weight (in_weight),
    .prod   (prod)
  );

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign acc_sum  = {acc[ACC_W-1], acc} + {{(ACC_W-IN_W){prod[IN_W]}}, prod};
  assign acc_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
  assign acc_next = acc_ovf ? {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}}
                            : acc_sum[ACC_W-1:0];

  assign fin_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};

  always_comb begin
    fin_clamp   = 1'b0;
    fin_clamped = fin_sum[OUT_W-1:0];
    if (fin_sum > OUT_MAX) begin
      fin_clamp   = 1'b1;
      fin_clamped = OUT_MAX[OUT_W-1:0];
    end else if (fin_sum < OUT_MIN) begin
      fin_clamp   = 1'b1;
      fin_clamped = OUT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    act_val = fin_clamped;
    case (ACT)
      ACT_SIGN: act_val = fin_clamped[OUT_W-1] ? {OUT_W{1'b1}} : {{(OUT_W-1){1'b0}}, 1'b1};
      ACT_RELU: act_val = fin_clamped[OUT_W-1] ? '0 : fin_clamped;
      default:  act_val = fin_clamped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      bias_q    <= '0;
      sat_acc   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bias_q  <= bias;
            acc     <= '0;
            idx     <= '0;
            sat_acc <= 1'b0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc     <= acc_next;
            sat_acc <= sat_acc | acc_ovf;
            if (idx == IDX_W'(N_INPUTS-1)) begin
              idx   <= '0;
              state <= S_FINISH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_FINISH: begin
          result    <= act_val;
          sat       <= sat_acc | fin_clamp;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        default: begin
          // start is deliberately ignored here, even on the handshake cycle
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready = (state == S_ACCUM);
  assign busy     = (state != S_IDLE);
  assign in_index = idx;

endmodule

// File: tb/tb_ternary_neuron.sv
// Bench for ternary_neuron: four parameter sets share one stimulus stream, each vector checks one of them.
module tb_ternary_neuron;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [3:0] bias;
  logic              in_valid;
  logic signed [1:0] in_data;
  logic [1:0]        in_weight;
  logic              out_ready;

  logic [3:0]        rdy, ov, sat, busy;
  logic [5:0]        idx [4];
  logic signed [6:0] res0, res2, res3;
  logic signed [5:0] res1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ternary_neuron #(.ACT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_weight(in_weight), .in_index(idx[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .result(res0), .sat(sat[0]), .busy(busy[0]));

  ternary_neuron #(.ACC_W(6), .OUT_W(6), .ACT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_weight(in_weight), .in_index(idx[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res1), .sat(sat[1]), .busy(busy[1]));

  ternary_neuron #(.ACT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_weight(in_weight), .in_index(idx[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .result(res2), .sat(sat[2]), .busy(busy[2]));

  ternary_neuron #(.ACT(2)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_data(in_data), .in_weight(in_weight), .in_index(idx[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .result(res3), .sat(sat[3]), .busy(busy[3]));

  typedef struct {
    int inst;
    int bias;
    int d0, w0, d1, w1, split;
    int exp_res;
    int exp_sat;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(int inst, int b, int d0, int w0, int d1, int w1, int split,
                              int er, int es);
    vec_t v;
    v.inst = inst; v.bias = b; v.d0 = d0; v.w0 = w0; v.d1 = d1; v.w1 = w1;
    v.split = split; v.exp_res = er; v.exp_sat = es;
    return v;
  endfunction

  function automatic int res_of(int inst);
    case (inst)
      0:       return int'(res0);
      1:       return int'(res1);
      2:       return int'(res2);
      default: return int'(res3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start a computation and feed all terms; returns at the negedge where out_valid is seen.
  task automatic run_vec(input vec_t v, input int gap, output int cyc, output bit idx_ok);
    int  k;
    bit  hs;
    k = 0; idx_ok = 1'b1;
    @(negedge clk);
    bias = 4'(v.bias); start = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      if (ov[v.inst]) break;
      if (k < 64) begin
        in_valid  = (gap == 0) || ($urandom_range(99) >= gap);
        in_data   = (k < v.split) ? 2'(v.d0) : 2'(v.d1);
        in_weight = (k < v.split) ? 2'(v.w0) : 2'(v.w1);
      end else begin
        in_valid = 1'b0;
      end
      if (rdy[v.inst] && (int'(idx[v.inst]) != k)) idx_ok = 1'b0;
      hs = in_valid && rdy[v.inst];
      @(posedge clk);
      cyc++;
      if (hs) k++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  idx_ok;
    string nm;

    tbl[0]  = mk(0, -3,  1, 1,  1, 1, 64,  61, 0);
    tbl[1]  = mk(1,  0, -2, 3, -2, 3, 64,  31, 1);
    tbl[2]  = mk(2,  0,  1, 1,  1, 3, 32,   1, 0);
    tbl[3]  = mk(3,  2,  1, 3,  1, 3, 64,   0, 0);
    tbl[4]  = mk(0,  0,  1, 3,  1, 3, 64, -64, 0);
    tbl[5]  = mk(0, -1,  1, 3,  1, 3, 64, -64, 1);
    tbl[6]  = mk(0,  7,  1, 1,  1, 1, 64,  63, 1);
    tbl[7]  = mk(0,  5,  1, 2,  1, 2, 64,   5, 0);
    tbl[8]  = mk(2, -1,  1, 1,  1, 3, 32,  -1, 0);
    tbl[9]  = mk(3,  7,  1, 1,  1, 1, 64,  63, 1);
    tbl[10] = mk(2,  0, -2, 1, -2, 1, 64,  -1, 1);
    tbl[11] = mk(1, -8, -2, 3, -2, 3, 64,  23, 1);
    tbl[12] = mk(0,  3, -2, 0,  1, 1, 32,  35, 0);
    tbl[13] = mk(3, -8, -1, 3, -1, 3, 64,  56, 0);

    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
    in_data = '0; in_weight = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", int'(ov),   0);
    chk("reset sat",       int'(sat),  0);
    chk("reset busy",      int'(busy), 0);
    chk("reset in_ready",  int'(rdy),  0);
    chk("reset in_index",  int'(idx[0]), 0);
    chk("reset result0",   int'(res0), 0);
    chk("reset result1",   int'(res1), 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i], 0, cyc, idx_ok);
      $sformat(nm, "vec%0d", i);
      chk({nm, " out_valid"}, int'(ov[tbl[i].inst]), 1);
      chk({nm, " latency"},   cyc, 66);
      chk({nm, " result"},    res_of(tbl[i].inst), tbl[i].exp_res);
      chk({nm, " sat"},       int'(sat[tbl[i].inst]), tbl[i].exp_sat);
      chk({nm, " in_index"},  int'(idx_ok), 1);
      consume();
    end

    // Random in_valid gaps must not change the answer.
    run_vec(tbl[0], 40, cyc, idx_ok);
    chk("gap out_valid", int'(ov[0]), 1);
    chk("gap result",    res_of(0), 61);
    chk("gap sat",       int'(sat[0]), 0);
    chk("gap in_index",  int'(idx_ok), 1);
    consume();

    // Result held while out_ready is low; a start pulse in OUT is ignored.
    run_vec(tbl[6], 0, cyc, idx_ok);
    for (int j = 0; j < 5; j++) begin
      chk("hold out_valid", int'(ov[0]), 1);
      chk("hold result",    res_of(0), 63);
      start = (j == 2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    consume();
    chk("after out busy",      int'(busy[0]), 0);
    chk("after out out_valid", int'(ov[0]), 0);
    chk("after out result",    res_of(0), 63);

    // Reset at term 20 aborts the run and clears every output.
    @(negedge clk);
    bias = 4'sd1; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 2'sd1; in_weight = 2'b01;
      @(posedge clk);
    end
    @(negedge clk);
    chk("pre-reset in_index", int'(idx[0]), 20);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset out_valid", int'(ov[0]), 0);
    chk("mid reset result",    res_of(0), 0);
    chk("mid reset sat",       int'(sat[0]), 0);
    chk("mid reset busy",      int'(busy[0]), 0);
    chk("mid reset in_ready",  int'(rdy[0]), 0);
    chk("mid reset in_index",  int'(idx[0]), 0);
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("aborted no result", int'(ov), 0);

    run_vec(tbl[0], 0, cyc, idx_ok);
    chk("post-reset out_valid", int'(ov[0]), 1);
    chk("post-reset latency",   cyc, 66);
    chk("post-reset result",    res_of(0), 61);
    chk("post-reset sat",       int'(sat[0]), 0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
